au_seq_divider: RTL and testbench

Sequential unsigned restoring divider. It is the inverse companion to the team's 6-bit add/subtract arithmetic unit: division is built from repeated trial subtraction, one quotient bit per clock.
- Operands enter through a valid/ready handshake.
- Quotient and remainder leave through a second valid/ready handshake.
- Sits beside the AU in the datapath and serves DIV requests from the control sequencer.

---
 rtl/au_seq_divider.sv | 101 ++++++++++
 tb/tb_au_seq_divider.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/au_seq_divider.sv
// au_seq_divider: restoring divider, one quotient bit per clock behind valid/ready handshakes.
// Define AU_DIV_SIGNED_EN for two's-complement operands (truncating division).
module au_seq_divider #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] q, r, d, a_mag, b_mag;
    logic [CW-1:0]    cnt;
    logic             dz, accept, zero;
    logic [WIDTH:0]   rem_shift, diff;

    assign accept    = in_valid && in_ready;
    assign zero      = divisor == '0;
    assign rem_shift = {r, q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, d};
    assign div_by_zero = dz;

`ifdef AU_DIV_SIGNED_EN
    logic q_neg, r_neg;

    // The core divides magnitudes; signs are reapplied on the way out.
    assign a_mag     = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag     = divisor[WIDTH-1] ? -divisor : divisor;
    assign quotient  = q_neg ? -q : q;
    assign remainder = r_neg ? -r : r;

    always_ff @(posedge clock) begin
        if (reset) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (accept) begin
            q_neg <= !zero && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= !zero && dividend[WIDTH-1];
        end
    end
`else
    assign a_mag     = dividend;
    assign b_mag     = divisor;
    assign quotient  = q;
    assign remainder = r;
`endif

    always_ff @(posedge clock) begin
        state <= reset ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = zero ? DONE : RUN;
            end
            RUN:  state_next = (cnt == '0) ? DONE : RUN;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // q doubles as the dividend shift register and the quotient accumulator.
    always_ff @(posedge clock) begin
        if (reset) begin
            q   <= '0;
            r   <= '0;
            d   <= '0;
            cnt <= '0;
            dz  <= 1'b0;
        end else if (accept) begin
            q   <= zero ? '1 : a_mag;
            r   <= zero ? dividend : '0;
            d   <= b_mag;
            cnt <= CW'(WIDTH - 1);
            dz  <= zero;
        end else if (state == RUN) begin
            r   <= diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], !diff[WIDTH]};
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_au_seq_divider.sv
// tb_au_seq_divider: directed and randomized checks of au_seq_divider against a transaction-level model.
module tb_au_seq_divider;
    localparam int W = 6;

    logic         clock = 1'b0;
    logic         reset, in_valid, out_ready;
    logic         in_ready, out_valid, div_by_zero;
    logic [W-1:0] dividend, divisor, quotient, remainder;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    au_seq_divider #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one division as {quotient, remainder, div_by_zero}.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        int qi, ri;
        if (b == '0) return {{W{1'b1}}, a, 1'b1};
`ifdef AU_DIV_SIGNED_EN
        qi = int'($signed(a)) / int'($signed(b));
        ri = int'($signed(a)) % int'($signed(b));
`else
        qi = int'(a) / int'(b);
        ri = int'(a) % int'(b);
`endif
        return {qi[W-1:0], ri[W-1:0], 1'b0};
    endfunction

    // Transaction model: busy from accept until the result is taken;
    // a result appears W edges after accept, or at once for a zero divisor.
    bit           busy;
    int           wait_cnt;
    logic [W-1:0] m_q, m_r;
    logic         m_dz;

    always @(posedge clock) begin
        if (reset) begin
            busy     <= 1'b0;
            wait_cnt <= 0;
        end else if (!busy) begin
            if (in_valid) begin
                busy              <= 1'b1;
                wait_cnt          <= (divisor == '0) ? 0 : W;
                {m_q, m_r, m_dz}  <= ref_div(dividend, divisor);
            end
        end else if (wait_cnt > 0) begin
            wait_cnt <= wait_cnt - 1;
        end else if (out_ready) begin
            busy <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            check("in_ready", in_ready, !busy);
            check("out_valid", out_valid, busy && wait_cnt == 0);
            if (busy && wait_cnt == 0) begin
                check("model quotient", quotient, m_q);
                check("model remainder", remainder, m_r);
                check("model div_by_zero", div_by_zero, m_dz);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input int elat, input int hold);
        int lat;
        @(negedge clock);
        check("ready before accept", in_ready, 1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = (hold == 0);
        @(negedge clock);
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        check("ready after accept", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("latency", lat, elat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edz);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            @(negedge clock);
            check("held valid", out_valid, 1);
            check("held quotient", quotient, eq);
            check("held remainder", remainder, er);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("idle after transfer", in_ready, 1);
        check("valid dropped", out_valid, 0);
    endtask

    initial begin
        int sel;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        armed = 1'b1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
`ifdef AU_DIV_SIGNED_EN
        check("pin -32/-1", ref_div(6'b100000, 6'b111111), {6'b100000, 6'd0, 1'b0});
        check("pin -13/4", ref_div(6'b110011, 6'd4), {6'b111101, 6'b111111, 1'b0});
        check("pin 5/0", ref_div(6'd5, 6'd0), {6'd63, 6'd5, 1'b1});
        run_op(6'b110011, 6'd4, 6'b111101, 6'b111111, 1'b0, W, 0);
        run_op(6'b100000, 6'b111111, 6'b100000, 6'd0, 1'b0, W, 0);
        run_op(6'b101101, 6'd7, 6'b111110, 6'b111011, 1'b0, W, 0);
        run_op(6'd5, 6'd0, 6'd63, 6'd5, 1'b1, 0, 0);
`else
        check("pin 45/7", ref_div(6'd45, 6'd7), {6'd6, 6'd3, 1'b0});
        check("pin 5/9", ref_div(6'd5, 6'd9), {6'd0, 6'd5, 1'b0});
        check("pin 5/0", ref_div(6'd5, 6'd0), {6'd63, 6'd5, 1'b1});
        run_op(6'd45, 6'd7, 6'd6, 6'd3, 1'b0, W, 0);
        run_op(6'd63, 6'd1, 6'd63, 6'd0, 1'b0, W, 0);
        run_op(6'd5, 6'd9, 6'd0, 6'd5, 1'b0, W, 0);
        run_op(6'd5, 6'd0, 6'd63, 6'd5, 1'b1, 0, 0);
        run_op(6'd50, 6'd6, 6'd8, 6'd2, 1'b0, W, 10);
        run_op(6'd0, 6'd5, 6'd0, 6'd0, 1'b0, W, 0);
        @(negedge clock);
        in_valid = 1'b1;
        dividend = 6'd40;
        divisor  = 6'd3;
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid reset quotient", quotient, 0);
        check("mid reset remainder", remainder, 0);
        check("mid reset div_by_zero", div_by_zero, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("no pulse after reset", out_valid, 0);
        end
        out_ready = 1'b0;
        run_op(6'd40, 6'd3, 6'd13, 6'd1, 1'b0, W, 0);
`endif
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            sel       = $urandom_range(0, 7);
            reset     = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            dividend  = W'($urandom);
            divisor   = (sel == 0) ? '0 : (sel == 1) ? W'(1) : (sel == 2) ? '1 : W'($urandom);
        end
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
